// File: rtl/div_32bit_seq.sv
// Radix-2 restoring sequential divider, RV32M DIV/DIVU/REM/REMU semantics.
// Accepts one operand pair per start and presents results WIDTH+1 cycles later.
//
// state | meaning
// IDLE  | waiting for start; results held from the last operation
// RUN   | one quotient bit per clock, counter counts WIDTH down to 1
// FIX   | sign correction, divide-by-zero override, result write, done pulse
module div_32bit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] dvnd_q, dvnd_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        dividend_mag = (is_signed && dividend[WIDTH-1]) ? (~dividend) + WIDTH'(1) : dividend;
        divisor_mag  = (is_signed && divisor[WIDTH-1])  ? (~divisor) + WIDTH'(1)  : divisor;
        // quo_q doubles as the dividend shift register: its MSB is the next bit in
        shifted      = {prem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial        = shifted - {1'b0, dvsr_q};
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        prem_d        = prem_q;
        quo_d         = quo_q;
        dvsr_d        = dvsr_q;
        dvnd_d        = dvnd_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dbz_d         = dbz_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = CW'(WIDTH);
                    prem_d    = '0;
                    quo_d     = dividend_mag;
                    dvsr_d    = divisor_mag;
                    dvnd_d    = dividend;
                    neg_quo_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed && dividend[WIDTH-1];
                    dbz_d     = (divisor == '0);
                end
            end
            RUN: begin
                if (!trial[WIDTH]) begin
                    prem_d = trial;
                    quo_d  = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_d = shifted;
                    quo_d  = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dbz_q) begin
                    quotient_d  = '1;
                    remainder_d = dvnd_q;
                end else begin
                    quotient_d  = neg_quo_q ? (~quo_q) + WIDTH'(1) : quo_q;
                    remainder_d = neg_rem_q ? (~prem_q[WIDTH-1:0]) + WIDTH'(1) : prem_q[WIDTH-1:0];
                end
                div_by_zero_d = dbz_q;
                done_d        = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            prem_q        <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            dvnd_q        <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prem_q        <= prem_d;
            quo_q         <= quo_d;
            dvsr_q        <= dvsr_d;
            dvnd_q        <= dvnd_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dbz_q         <= dbz_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            done_q        <= done_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_div_32bit_seq.sv
// Directed bench for div_32bit_seq: latency, signed/unsigned results,
// divide-by-zero, overflow, start handshake and mid-operation reset.
module tb_div_32bit_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    div_32bit_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; returns #1 after the accepting edge (cycle 0).
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    // Called in cycle 0; waits for done, checks latency, busy profile and results.
    // With disturb set, operands are scrambled and start is toggled while busy.
    task automatic wait_result(input string tag, input logic disturb,
                               input logic [31:0] exp_q, input logic [31:0] exp_r,
                               input logic exp_dbz);
        int k;
        int bad_busy;
        bad_busy = 0;
        k = 0;
        while (k < 100 && !done) begin
            if (!busy) bad_busy++;
            if (disturb) begin
                dividend  = $urandom;
                divisor   = $urandom;
                is_signed = 1'(k);
                start     = 1'(k);
            end
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(k), 32'd33);
        check({tag, "_busy_run"}, 32'(bad_busy), 32'd0);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_quo"}, quotient, exp_q);
        check({tag, "_rem"}, remainder, exp_r);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input logic exp_dbz);
        launch(s, a, b);
        wait_result(tag, 1'b0, exp_q, exp_r, exp_dbz);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int seen_done;
        rst_n     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #1 rst_n  = 1'b0;
        #2;
        check("rst_quo", quotient, 32'd0);
        check("rst_rem", remainder, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("u222_111", 1'b0, 32'd222, 32'd111, 32'd2, 32'd0, 1'b0);
        run_op("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("s_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_op("s_m7_m2",  1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);
        run_op("u_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
        run_op("u_dbz",    1'b0, 32'd408, 32'd0, 32'hFFFF_FFFF, 32'd408, 1'b1);
        run_op("s_dbz",    1'b1, 32'hFFFF_FF98, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF98, 1'b1);
        run_op("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run_op("u_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op("u_lt",     1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0);

        // Results hold between operations.
        repeat (3) @(posedge clk);
        #1;
        check("hold_quo", quotient, 32'd0);
        check("hold_rem", remainder, 32'd5);

        // Disturbed operation followed by a start in its done cycle.
        launch(1'b0, 32'd1000, 32'd7);
        wait_result("disturb", 1'b1, 32'd142, 32'd6, 1'b0);
        launch(1'b0, 32'd45, 32'd123);
        check("b2b_hold_quo", quotient, 32'd142);
        wait_result("b2b", 1'b0, 32'd0, 32'd45, 1'b0);

        // Reset in cycle 10 of an operation.
        @(posedge clk);
        #1;
        launch(1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_quo", quotient, 32'd0);
        check("mid_rst_rem", remainder, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        check("mid_rst_no_done", 32'(seen_done), 32'd0);
        run_op("after_rst", 1'b0, 32'd342, 32'd111, 32'd3, 32'd9, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
